aes_bus_initiator: RTL and testbench
====================================

AES_BUS_INITIATOR -- requirements
Module: aes_bus_initiator

Interface
REQ-001 SHALL have parameter SOURCE_ID, default 2'b00: own source id placed in every header.
REQ-002 SHALL have parameter PAYLOAD_BYTES, default 16: payload bytes per payload-carrying frame.
REQ-003 SHALL have parameter ACK_TIMEOUT, default 255: ACK_WAIT cycle limit (used only when timeout compiled in).
REQ-004 clk  in  1  single clock, all logic on rising edge.
REQ-005 rst_n  in  1  synchronous, active-low reset.
REQ-006 cmd_valid/cmd_ready  in/out  1/1  command handshake.
REQ-007 cmd_opcode  in  2  00 LOAD_KEY, 01 LOAD_TEXT, 10 START, 11 READ_RESULT.
REQ-008 cmd_dest_id  in  2  target module id.
REQ-009 cmd_encdec  in  1  1=encrypt, 0=decrypt.
REQ-010 cmd_addr  in  24  target address.
REQ-011 wr_data/wr_valid/wr_ready  in/in/out  8/1/1  payload byte stream.
REQ-012 bus_data  out  8  byte to core data_in.
REQ-013 bus_valid/bus_ready  out/in  1/1  bus byte handshake (bus_ready = core ready_in).
REQ-014 ack_valid/ack_ready/ack_source_id  in/out/in  1/1/2  completion ack from core.
REQ-015 busy/done/err  out  1/1/1  status; done and err are one-cycle pulses.

Function
REQ-016 States SHALL be IDLE, HDR, ADDR, DATA, ACK_WAIT.
REQ-017 cmd_ready SHALL be 1 only in IDLE; cmd_valid&&cmd_ready latches opcode/dest/encdec/addr and enters HDR next cycle.
REQ-018 Bus byte transfers SHALL occur only on bus_valid&&bus_ready; bus_data/bus_valid registered, held stable while bus_valid&&!bus_ready.
REQ-019 HDR SHALL present header {opcode[1:0], SOURCE_ID[1:0], dest_id[1:0], encdec, 1'b0}.
REQ-020 ADDR SHALL present addr[23:16], addr[15:8], addr[7:0] in that order (2-bit counter).
REQ-021 After the 3rd address byte transfers: opcode 00/01 -> DATA; opcode 10/11 -> ACK_WAIT.
REQ-022 In DATA, wr_ready SHALL equal (!bus_valid || bus_ready); accepted wr byte loads bus_data next cycle with bus_valid=1.
REQ-023 DATA SHALL count transferred bytes; after byte PAYLOAD_BYTES transfers, go to ACK_WAIT; wr_ready=0 once PAYLOAD_BYTES accepted.
REQ-024 bus_valid SHALL deassert the cycle after the final byte transfers unless another byte is loaded.
REQ-025 In ACK_WAIT, ack_ready SHALL be 1; ack_valid&&ack_ready ends the frame and returns to IDLE.
REQ-026 On ack, ack_source_id==dest_id SHALL pulse done; mismatch SHALL pulse err instead.
REQ-027 busy SHALL be 1 in every state except IDLE.
REQ-028 cmd_valid outside IDLE SHALL be ignored (no queueing).
REQ-029 ack_valid outside ACK_WAIT SHALL be ignored; ack_ready=0 there.
REQ-030 wr_valid outside DATA SHALL be ignored; wr_ready=0 there.

Reset
REQ-031 rst_n=0 at a clock edge SHALL force IDLE, clear counters and latched command, from any state including mid-frame.
REQ-032 Reset values: cmd_ready=1 (IDLE), wr_ready=0, bus_valid=0, bus_data=8'h00, ack_ready=0, busy=0, done=0, err=0.

Configuration
REQ-033 Macro AES_INIT_TIMEOUT_EN defined: 8-bit+ counter clears on ACK_WAIT entry, increments each ACK_WAIT cycle; reaching ACK_TIMEOUT without ack pulses err and returns to IDLE.
REQ-034 Macro undefined: no counter; ACK_WAIT waits indefinitely; err only from source-id mismatch.

Verification
REQ-035 LOAD_KEY, dest 01, encdec 1, addr 24'hABCDEF, payload 00..0F, bus_ready=1 -> bus bytes 8'h0A? no: header 8'b00_00_01_1_0=8'h06, then AB,CD,EF,00..0F (20 bytes); ack id 01 -> done pulse, busy falls.
REQ-036 START, dest 10 -> exactly 4 bus bytes (header 8'h88 with encdec 0), no wr_ready; ack id 10 -> done.
REQ-037 LOAD_TEXT with bus_ready toggled 1/0 every cycle -> bus_data stable while stalled, byte order intact, 20 transfers total.
REQ-038 Ack with ack_source_id 11 while dest 01 -> err pulse, done=0, IDLE next cycle.
REQ-039 rst_n=0 during DATA byte 7 -> next cycle all outputs at reset values; new command then runs cleanly.
REQ-040 AES_INIT_TIMEOUT_EN, ACK_TIMEOUT=10, no ack -> err pulse after 10 ACK_WAIT cycles, cmd_ready=1 next cycle.

Source files
------------

// File: rtl/aes_bus_initiator_if.sv
// Command, payload, byte-bus, ack and status signals between the AES bus initiator and its neighbours.
// The master modport is the initiator's view. The slave modport is the view of the command source, core and status sink.
interface aes_bus_initiator_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_opcode;
    logic [1:0]  cmd_dest_id;
    logic        cmd_encdec;
    logic [23:0] cmd_addr;

    logic [7:0]  wr_data;
    logic        wr_valid;
    logic        wr_ready;

    logic [7:0]  bus_data;
    logic        bus_valid;
    logic        bus_ready;

    logic        ack_valid;
    logic        ack_ready;
    logic [1:0]  ack_source_id;

    logic        busy;
    logic        done;
    logic        err;

    modport master (
        input  cmd_valid, cmd_opcode, cmd_dest_id, cmd_encdec, cmd_addr,
        input  wr_data, wr_valid, bus_ready, ack_valid, ack_source_id,
        output cmd_ready, wr_ready, bus_data, bus_valid, ack_ready, busy, done, err
    );

    modport slave (
        output cmd_valid, cmd_opcode, cmd_dest_id, cmd_encdec, cmd_addr,
        output wr_data, wr_valid, bus_ready, ack_valid, ack_source_id,
        input  cmd_ready, wr_ready, bus_data, bus_valid, ack_ready, busy, done, err
    );
endinterface

// File: rtl/aes_bus_initiator.sv
// Frames one AES command (header, 3 address bytes, optional payload) onto a byte bus, then waits for the core's ack.
// Latency: the header is on the bus the cycle after cmd accept, and each bus byte moves on bus_valid&&bus_ready. bus_ready stalls hold the byte in place; wr_ready throttles the payload.
// Define AES_INIT_TIMEOUT_EN to abandon ACK_WAIT after ACK_TIMEOUT cycles with an err pulse.
module aes_bus_initiator #(
    parameter logic [1:0] SOURCE_ID     = 2'b00,
    parameter int         PAYLOAD_BYTES = 16,
    parameter int         ACK_TIMEOUT   = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    aes_bus_initiator_if.master bus
);

    localparam int CW = $clog2(PAYLOAD_BYTES + 1);

    if (PAYLOAD_BYTES < 1 || ACK_TIMEOUT < 1) begin : g_bad_params
        $error("aes_bus_initiator: PAYLOAD_BYTES and ACK_TIMEOUT must be at least 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_ADDR,
        S_DATA,
        S_ACK_WAIT
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [1:0]      r_opcode;
    logic [1:0]      w_opcode_nxt;
    logic [1:0]      r_dest;
    logic [1:0]      w_dest_nxt;
    logic [23:0]     r_addr;
    logic [23:0]     w_addr_nxt;
    logic [1:0]      r_addr_idx;
    logic [1:0]      w_addr_idx_nxt;
    logic [CW-1:0]   r_acc_cnt;
    logic [CW-1:0]   w_acc_cnt_nxt;
    logic [CW-1:0]   r_xfer_cnt;
    logic [CW-1:0]   w_xfer_cnt_nxt;
    logic [7:0]      r_bus_data;
    logic [7:0]      w_bus_data_nxt;
    logic            r_bus_valid;
    logic            w_bus_valid_nxt;
    logic            r_done;
    logic            w_done_nxt;
    logic            r_err;
    logic            w_err_nxt;

    logic            w_xfer;
    logic            w_wr_ready;
    logic            w_wr_fire;
    logic            w_no_payload;

`ifdef AES_INIT_TIMEOUT_EN
    localparam int TW = ($clog2(ACK_TIMEOUT + 1) > 8) ? $clog2(ACK_TIMEOUT + 1) : 8;
    logic [TW-1:0]   r_to_cnt;
    logic [TW-1:0]   w_to_cnt_nxt;
`endif

    assign w_xfer       = r_bus_valid && bus.bus_ready;
    // The payload stage can take a new byte once the previous one has left or is leaving this cycle.
    assign w_wr_ready   = (r_state == S_DATA) && (r_acc_cnt < CW'(PAYLOAD_BYTES))
                          && (!r_bus_valid || bus.bus_ready);
    assign w_wr_fire    = w_wr_ready && bus.wr_valid;
    assign w_no_payload = (r_opcode == 2'b10) || (r_opcode == 2'b11);

    always_comb begin
        w_state_nxt     = r_state;
        w_opcode_nxt    = r_opcode;
        w_dest_nxt      = r_dest;
        w_addr_nxt      = r_addr;
        w_addr_idx_nxt  = r_addr_idx;
        w_acc_cnt_nxt   = r_acc_cnt;
        w_xfer_cnt_nxt  = r_xfer_cnt;
        w_bus_data_nxt  = r_bus_data;
        w_bus_valid_nxt = r_bus_valid;
        w_done_nxt      = 1'b0;
        w_err_nxt       = 1'b0;
`ifdef AES_INIT_TIMEOUT_EN
        w_to_cnt_nxt    = '0;
`endif

        case (r_state)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    w_opcode_nxt    = bus.cmd_opcode;
                    w_dest_nxt      = bus.cmd_dest_id;
                    w_addr_nxt      = bus.cmd_addr;
                    w_addr_idx_nxt  = 2'd0;
                    w_acc_cnt_nxt   = '0;
                    w_xfer_cnt_nxt  = '0;
                    // encdec is only needed in the header, so it lives in this byte.
                    w_bus_data_nxt  = {bus.cmd_opcode, SOURCE_ID, bus.cmd_dest_id, bus.cmd_encdec, 1'b0};
                    w_bus_valid_nxt = 1'b1;
                    w_state_nxt     = S_HDR;
                end
            end
            S_HDR: begin
                if (w_xfer) begin
                    w_bus_data_nxt = r_addr[23:16];
                    w_addr_idx_nxt = 2'd0;
                    w_state_nxt    = S_ADDR;
                end
            end
            S_ADDR: begin
                if (w_xfer) begin
                    if (r_addr_idx == 2'd2) begin
                        w_bus_valid_nxt = 1'b0;
                        w_state_nxt     = w_no_payload ? S_ACK_WAIT : S_DATA;
                    end else begin
                        w_addr_idx_nxt = r_addr_idx + 2'd1;
                        w_bus_data_nxt = (r_addr_idx == 2'd0) ? r_addr[15:8] : r_addr[7:0];
                    end
                end
            end
            S_DATA: begin
                if (w_wr_fire) begin
                    w_bus_data_nxt  = bus.wr_data;
                    w_bus_valid_nxt = 1'b1;
                    w_acc_cnt_nxt   = r_acc_cnt + CW'(1);
                end else if (w_xfer) begin
                    w_bus_valid_nxt = 1'b0;
                end
                if (w_xfer) begin
                    w_xfer_cnt_nxt = r_xfer_cnt + CW'(1);
                    if (r_xfer_cnt == CW'(PAYLOAD_BYTES - 1)) begin
                        w_state_nxt = S_ACK_WAIT;
                    end
                end
            end
            S_ACK_WAIT: begin
                if (bus.ack_valid) begin
                    w_done_nxt  = (bus.ack_source_id == r_dest);
                    w_err_nxt   = (bus.ack_source_id != r_dest);
                    w_state_nxt = S_IDLE;
`ifdef AES_INIT_TIMEOUT_EN
                end else if (r_to_cnt == TW'(ACK_TIMEOUT - 1)) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_to_cnt_nxt = r_to_cnt + TW'(1);
`endif
                end
            end
            default: begin
                w_state_nxt     = S_IDLE;
                w_bus_valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_opcode    <= 2'b00;
            r_dest      <= 2'b00;
            r_addr      <= 24'h000000;
            r_addr_idx  <= 2'd0;
            r_acc_cnt   <= '0;
            r_xfer_cnt  <= '0;
            r_bus_data  <= 8'h00;
            r_bus_valid <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
`ifdef AES_INIT_TIMEOUT_EN
            r_to_cnt    <= '0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_opcode    <= w_opcode_nxt;
            r_dest      <= w_dest_nxt;
            r_addr      <= w_addr_nxt;
            r_addr_idx  <= w_addr_idx_nxt;
            r_acc_cnt   <= w_acc_cnt_nxt;
            r_xfer_cnt  <= w_xfer_cnt_nxt;
            r_bus_data  <= w_bus_data_nxt;
            r_bus_valid <= w_bus_valid_nxt;
            r_done      <= w_done_nxt;
            r_err       <= w_err_nxt;
`ifdef AES_INIT_TIMEOUT_EN
            r_to_cnt    <= w_to_cnt_nxt;
`endif
        end
    end

    assign bus.cmd_ready = (r_state == S_IDLE);
    assign bus.wr_ready  = w_wr_ready;
    assign bus.bus_data  = r_bus_data;
    assign bus.bus_valid = r_bus_valid;
    assign bus.ack_ready = (r_state == S_ACK_WAIT);
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.done      = r_done;
    assign bus.err       = r_err;

endmodule

// File: tb/tb_aes_bus_initiator.sv
// Directed scoreboard bench for aes_bus_initiator. Stimulus pushes expected bus bytes and status pulses.
// A negedge monitor pops and compares them whenever the DUT transfers a byte or raises done/err.
module tb_aes_bus_initiator;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    aes_bus_initiator_if bif();

    aes_bus_initiator #(
        .SOURCE_ID     (2'b00),
        .PAYLOAD_BYTES (16),
        .ACK_TIMEOUT   (10)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] exp_bus[$];
    logic [1:0] exp_stat[$];
    int n_xfer = 0;
    int n_stalls = 0;
    int wr_rdy_seen = 0;
    bit toggle_rdy = 1'b0;
    logic stall_pend = 1'b0;
    logic [7:0] stall_dat = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: samples at negedge, inputs only change 1 time unit after posedge.
    always @(negedge clk) begin
        if (stall_pend) begin
            check("stall_hold", {23'd0, bif.bus_valid, bif.bus_data}, {23'd0, 1'b1, stall_dat});
        end
        stall_pend = rst_n && bif.bus_valid && !bif.bus_ready;
        stall_dat  = bif.bus_data;
        if (stall_pend) n_stalls++;
        if (bif.bus_valid && bif.bus_ready) begin
            n_xfer++;
            if (exp_bus.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL bus_unexpected: got byte %0h expected no transfer", bif.bus_data);
            end else begin
                check("bus_byte", {24'd0, bif.bus_data}, {24'd0, exp_bus.pop_front()});
            end
        end
        if (bif.done || bif.err) begin
            if (exp_stat.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL status_unexpected: got done=%0b err=%0b expected no pulse", bif.done, bif.err);
            end else begin
                check("status_pulse", {30'd0, bif.done, bif.err}, {30'd0, exp_stat.pop_front()});
            end
        end
        if (bif.wr_ready) wr_rdy_seen++;
    end

    always @(posedge clk) begin
        #1;
        if (toggle_rdy) bif.bus_ready = ~bif.bus_ready;
    end

    task automatic send_cmd(input logic [1:0] op, input logic [1:0] dest, input logic enc,
                            input logic [23:0] addr, input logic [7:0] exp_hdr);
        int t = 0;
        exp_bus.push_back(exp_hdr);
        exp_bus.push_back(addr[23:16]);
        exp_bus.push_back(addr[15:8]);
        exp_bus.push_back(addr[7:0]);
        while (!bif.cmd_ready && t < 200) begin
            tick();
            t++;
        end
        if (!bif.cmd_ready) fail_now("cmd_ready_wait");
        bif.cmd_opcode  = op;
        bif.cmd_dest_id = dest;
        bif.cmd_encdec  = enc;
        bif.cmd_addr    = addr;
        bif.cmd_valid   = 1'b1;
        tick();
        bif.cmd_valid   = 1'b0;
    endtask

    task automatic push_payload(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) exp_bus.push_back(base + 8'(i));
    endtask

    task automatic send_payload(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) begin
            int t = 0;
            logic acc = 1'b0;
            bif.wr_valid = 1'b1;
            bif.wr_data  = base + 8'(i);
            while (!acc && t < 500) begin
                @(negedge clk);
                acc = bif.wr_ready;
                tick();
                t++;
            end
            if (!acc) begin
                fail_now("wr_ready_wait");
                break;
            end
        end
        bif.wr_valid = 1'b0;
    endtask

    task automatic wait_ack_ready();
        int t = 0;
        while (!bif.ack_ready && t < 500) begin
            tick();
            t++;
        end
        if (!bif.ack_ready) fail_now("ack_ready_wait");
    endtask

    task automatic send_ack(input logic [1:0] id, input logic [1:0] exp_st);
        wait_ack_ready();
        check("bus_drained", exp_bus.size(), 0);
        exp_stat.push_back(exp_st);
        bif.ack_source_id = id;
        bif.ack_valid     = 1'b1;
        tick();
        bif.ack_valid     = 1'b0;
        @(negedge clk);
        check("idle_after_ack", {29'd0, bif.cmd_ready, bif.busy, bif.ack_ready}, {29'd0, 3'b100});
    endtask

    task automatic check_reset_outputs(input string name);
        check(name, {17'd0, bif.cmd_ready, bif.wr_ready, bif.bus_valid, bif.bus_data,
                     bif.ack_ready, bif.busy, bif.done, bif.err},
                    {17'd0, 1'b1, 1'b0, 1'b0, 8'h00, 4'b0000});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int x0;
        bif.cmd_valid = 1'b0; bif.cmd_opcode = 2'b00; bif.cmd_dest_id = 2'b00;
        bif.cmd_encdec = 1'b0; bif.cmd_addr = 24'h0;
        bif.wr_data = 8'h00; bif.wr_valid = 1'b0; bif.bus_ready = 1'b1;
        bif.ack_valid = 1'b0; bif.ack_source_id = 2'b00;
        rst_n = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check_reset_outputs("reset_state");
        tick();
        rst_n = 1'b1;
        tick();

        // LOAD_KEY, dest 01, encrypt, full payload at full rate.
        x0 = n_xfer;
        send_cmd(2'b00, 2'b01, 1'b1, 24'hABCDEF, 8'h06);
        push_payload(16, 8'h00);
        send_payload(16, 8'h00);
        send_ack(2'b01, 2'b10);
        check("t1_xfer_count", n_xfer - x0, 20);

        // START, dest 10: header and address only; stray wr_valid/cmd_valid must be ignored.
        x0 = n_xfer;
        wr_rdy_seen = 0;
        bif.wr_valid = 1'b1;
        bif.wr_data  = 8'hEE;
        send_cmd(2'b10, 2'b10, 1'b0, 24'h123456, 8'h88);
        wait_ack_ready();
        bif.cmd_opcode = 2'b00;
        bif.cmd_valid  = 1'b1;
        repeat (3) tick();
        bif.cmd_valid  = 1'b0;
        bif.wr_valid   = 1'b0;
        send_ack(2'b10, 2'b10);
        check("t2_xfer_count", n_xfer - x0, 4);
        check("t2_no_wr_ready", wr_rdy_seen, 0);

        // Ack pulses while IDLE must not produce status.
        bif.ack_source_id = 2'b01;
        bif.ack_valid = 1'b1;
        repeat (2) tick();
        bif.ack_valid = 1'b0;

        // LOAD_TEXT with bus_ready toggling every cycle.
        x0 = n_xfer;
        n_stalls = 0;
        toggle_rdy = 1'b1;
        send_cmd(2'b01, 2'b01, 1'b0, 24'h010203, 8'h44);
        push_payload(16, 8'h10);
        send_payload(16, 8'h10);
        send_ack(2'b01, 2'b10);
        toggle_rdy = 1'b0;
        bif.bus_ready = 1'b1;
        check("t3_xfer_count", n_xfer - x0, 20);
        check("t3_saw_stalls", {31'd0, n_stalls != 0}, 1);

        // READ_RESULT, dest 01, ack from the wrong source.
        send_cmd(2'b11, 2'b01, 1'b1, 24'h00FF00, 8'hC6);
        send_ack(2'b11, 2'b01);

        // Reset mid-payload, then a clean START.
        send_cmd(2'b00, 2'b01, 1'b1, 24'h0A0B0C, 8'h06);
        push_payload(16, 8'h20);
        send_payload(6, 8'h20);
        bif.wr_valid = 1'b1;
        bif.wr_data  = 8'h26;
        rst_n = 1'b0;
        tick();
        bif.wr_valid = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset_mid_frame");
        exp_bus.delete();
        tick();
        rst_n = 1'b1;
        x0 = n_xfer;
        send_cmd(2'b10, 2'b11, 1'b1, 24'h000001, 8'h8E);
        send_ack(2'b11, 2'b10);
        check("t5_xfer_count", n_xfer - x0, 4);

`ifdef AES_INIT_TIMEOUT_EN
        begin
            int cyc = 0;
            send_cmd(2'b10, 2'b01, 1'b0, 24'h000000, 8'h84);
            wait_ack_ready();
            exp_stat.push_back(2'b01);
            while (cyc < 100) begin
                @(negedge clk);
                if (!bif.ack_ready) break;
                cyc++;
            end
            check("timeout_cycles", cyc, 10);
            check("timeout_idle", {31'd0, bif.cmd_ready}, 1);
            tick();
        end
`else
        send_cmd(2'b10, 2'b01, 1'b0, 24'h000000, 8'h84);
        wait_ack_ready();
        repeat (40) tick();
        check("no_timeout_wait", {30'd0, bif.ack_ready, bif.busy}, 2'b11);
        send_ack(2'b01, 2'b10);
`endif

        repeat (3) tick();
        check("bus_queue_empty", exp_bus.size(), 0);
        check("stat_queue_empty", exp_stat.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
